pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB).
//  Detects load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
//  Drives per-register enable and bubble controls plus pc_en. Keeps a saturating stall-cycle
//  counter and a sticky memory-timeout error flag.
// PARAMETERS
//  MAX_WAIT  16  max consecutive MEM_WAIT cycles before mem_timeout is set
//  CNT_W     16  width of stall_cycles counter
// PORTS
//  clk            in   1      single clock, all state updates on posedge
//  rst            in   1      synchronous, active-high reset
//  id_rs          in   5      rs field of instruction in ID
//  id_rt          in   5      rt field of instruction in ID
//  id_uses_rt     in   1      ID instruction reads rt as a source
//  ex_mem_read    in   1      instruction in EX is a load (ID_EX.M MemRead)
//  ex_rt_dest     in   5      destination register of instruction in EX
//  ex_branch_tkn  in   1      branch resolved taken in EX this cycle
//  mem_req        in   1      MEM-stage instruction accesses data memory
//  mem_ready      in   1      data memory completes access this cycle
//  pc_en          out  1      PC load enable
//  if_id_en       out  1      IF_ID load enable
//  if_id_flush    out  1      IF_ID loads NOP
//  id_ex_en       out  1      ID_EX load enable
//  id_ex_flush    out  1      ID_EX loads bubble (WB/M control = 0)
//  ex_mem_en      out  1      EX_MEM load enable
//  mem_wb_bubble  out  1      MEM_WB loads bubble (RegWrite=0)
//  stall_cycles   out  CNT_W  saturating count of cycles with pc_en=0
//  mem_timeout    out  1      sticky: wait exceeded MAX_WAIT
// BEHAVIOUR
//  - FSM states: RUN, MEM_WAIT, HALT. Reset: state=RUN, wait_cnt=0, stall_cycles=0, mem_timeout=0.
//  - While rst=1: all *_en=0, all flush/bubble=1 (registers clear to bubbles).
//  - Control outputs are combinational from state and inputs. State and counters are registered.
//  - Hazard terms:
//    memw = mem_req & ~mem_ready
//    lu   = ex_mem_read & ex_rt_dest!=0 & (ex_rt_dest==id_rs | (id_uses_rt & ex_rt_dest==id_rt))
//  - Priority: HALT > memw > ex_branch_tkn > lu > normal.
//  - Normal: every enable=1, every flush/bubble=0.
//  - memw (RUN or MEM_WAIT): pc_en, if_id_en, id_ex_en and ex_mem_en all =0; mem_wb_bubble=1.
//    The branch and load-use terms are ignored, because the EX inputs are frozen and re-evaluated after the wait.
//  - ex_branch_tkn (no memw): pc_en=1 (loads target), if_id_flush=1, id_ex_flush=1, other enables=1.
//  - lu (no memw, no branch): pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. Produces exactly one bubble,
//    because the load advances and lu drops the next cycle.
//  - Transitions:
//    RUN->MEM_WAIT when memw, wait_cnt<=1.
//    MEM_WAIT stays while memw, wait_cnt++.
//    MEM_WAIT->RUN on mem_ready, wait_cnt<=0.
//    memw with wait_cnt==MAX_WAIT -> HALT, mem_timeout<=1.
//  - HALT: outputs identical to memw; exits only by rst.
//  - A mem_ready arriving in the same cycle as mem_req is a zero-wait access: stay in RUN.
//  - stall_cycles increments on every non-reset cycle with pc_en=0 and saturates at all-ones.
//  - A register-0 destination never raises lu. Reset asserted mid-wait aborts the wait the next cycle.
// STRUCTURE
//  - pipeline_pkg: state enum {RUN, MEM_WAIT, HALT}, REG_IDX_W=5, NOP_INSTR constant.
//  - Sub-module sat_counter #(W) for stall_cycles; FSM and hazard terms stay inline.
// TESTING
//  - Reset: rst=1 for 2 cycles -> all en=0, flush=1; after release pc_en=1, stall_cycles=0, mem_timeout=0.
//  - Load-use: ex_mem_read=1, ex_rt_dest=5, id_rs=5 -> one cycle with pc_en=0, id_ex_flush=1; next cycle normal.
//  - Reg 0: ex_mem_read=1, ex_rt_dest=0, id_rs=0 -> no stall.
//  - Branch + load-use together: ex_branch_tkn=1 and lu=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1.
//  - Mem wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 frozen cycles with mem_wb_bubble=1,
//    then RUN; stall_cycles=3.
//  - Timeout: MAX_WAIT=4, mem_ready held 0 -> mem_timeout=1 after the 5th wait cycle, stays in HALT;
//    rst clears it.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   state_t   : sequencer state (RUN, MEM_WAIT, HALT)
//   REG_IDX_W : width of a register index field
//   NOP_INSTR : encoding loaded into IF_ID when it is flushed
package pipeline_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   count : current value, holds at all-ones
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
// Inputs : ID source fields (id_rs, id_rt, id_uses_rt), EX load info (ex_mem_read,
//          ex_rt_dest), taken branch (ex_branch_tkn), data-memory handshake
//          (mem_req, mem_ready).
// Outputs: pc_en and per-register enable/flush/bubble controls, a saturating count
//          of cycles with pc_en low (stall_cycles), sticky memory timeout flag.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rt_dest,
  input  logic                 ex_branch_tkn,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_flush,
  output logic                 id_ex_en,
  output logic                 id_ex_flush,
  output logic                 ex_mem_en,
  output logic                 mem_wb_bubble,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic                 mem_timeout
);

  localparam int unsigned WC_W = $clog2(MAX_WAIT + 1);

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              memw, lu, freeze;

  assign memw = mem_req & ~mem_ready;
  assign lu   = ex_mem_read && (ex_rt_dest != '0) &&
                ((ex_rt_dest == id_rs) || (id_uses_rt && (ex_rt_dest == id_rt)));
  // HALT presents the same frozen outputs as an ongoing memory wait.
  assign freeze = memw || (state_q == HALT);

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_en      = 1'b0;
      id_ex_flush   = 1'b1;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_tkn) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (lu) begin
      // Hold PC and IF_ID, insert one bubble into ID_EX while the load moves on.
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_flush   = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (memw) begin
          if (wait_cnt_q == WC_W'(MAX_WAIT)) begin
            state_d       = HALT;
            mem_timeout_d = 1'b1;
          end else begin
            state_d    = MEM_WAIT;
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  logic stall_inc;
  assign stall_inc = ~pc_en;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] NORM = 7'b1101010;
  localparam logic [6:0] RSTV = 7'b0010101;
  localparam logic [6:0] MEMW = 7'b0000001;
  localparam logic [6:0] BR   = 7'b1111110;
  localparam logic [6:0] LU   = 7'b0001110;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt_dest;
  logic       id_uses_rt, ex_mem_read, ex_branch_tkn, mem_req, mem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble;
  logic [3:0] stall_cycles;
  logic       mem_timeout;

  pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_mem_read   (ex_mem_read),
    .ex_rt_dest    (ex_rt_dest),
    .ex_branch_tkn (ex_branch_tkn),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .if_id_flush   (if_id_flush),
    .id_ex_en      (id_ex_en),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_bubble (mem_wb_bubble),
    .stall_cycles  (stall_cycles),
    .mem_timeout   (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string      name_q[$];
  logic [6:0] ctrl_q[$];
  logic [3:0] stall_q[$];
  logic       to_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [3:0]  stall_model = '0;

  // Drive one cycle of inputs and queue what the DUT must show during that cycle.
  task automatic step(input string nm, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mrd, input logic [4:0] dst, input logic br,
                      input logic req, input logic rdy, input logic [6:0] ectrl, input logic eto);
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mrd;
    ex_rt_dest = dst; ex_branch_tkn = br; mem_req = req; mem_ready = rdy;
    name_q.push_back(nm);
    ctrl_q.push_back(ectrl);
    stall_q.push_back(stall_model);
    to_q.push_back(eto);
    if (r) stall_model = '0;
    else if (!ectrl[6] && stall_model != 4'hF) stall_model = stall_model + 4'd1;
  endtask

  task automatic idle(input string nm, input logic [6:0] ectrl, input logic eto);
    step(nm, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ectrl, eto);
  endtask

  task automatic memw(input string nm, input logic eto);
    step(nm, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MEMW, eto);
  endtask

  task automatic reset_cycle(input string nm, input logic eto);
    step(nm, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RSTV, eto);
  endtask

  always @(negedge clk) begin
    if (name_q.size() != 0) begin
      string      nm;
      logic [6:0] ec, ac;
      logic [3:0] es;
      logic       et;
      nm = name_q.pop_front();
      ec = ctrl_q.pop_front();
      es = stall_q.pop_front();
      et = to_q.pop_front();
      ac = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble};
      n_cmp++;
      if (ac !== ec) begin
        n_bad++;
        $display("FAIL %s ctrl: got %b want %b", nm, ac, ec);
      end
      n_cmp++;
      if (stall_cycles !== es) begin
        n_bad++;
        $display("FAIL %s stall_cycles: got %0d want %0d", nm, stall_cycles, es);
      end
      n_cmp++;
      if (mem_timeout !== et) begin
        n_bad++;
        $display("FAIL %s mem_timeout: got %b want %b", nm, mem_timeout, et);
      end
    end
  end

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_rt_dest = '0; ex_branch_tkn = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

    reset_cycle("rst0", 1'b0);
    reset_cycle("rst1", 1'b0);
    idle("post_rst", NORM, 1'b0);
    //   name          r     rs     rt     urt   mrd   dst    br    req   rdy   ctrl  to
    step("lu_rs",      1'b0, 5'd5,  5'd9,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, LU,   1'b0);
    step("after_lu",   1'b0, 5'd5,  5'd9,  1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, NORM, 1'b0);
    step("lu_rt",      1'b0, 5'd3,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, LU,   1'b0);
    step("rt_unused",  1'b0, 5'd3,  5'd7,  1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, NORM, 1'b0);
    step("reg0",       1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, NORM, 1'b0);
    step("branch",     1'b0, 5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, BR,   1'b0);
    step("br_and_lu",  1'b0, 5'd5,  5'd2,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, BR,   1'b0);

    reset_cycle("rst2", 1'b0);
    step("mw1_br_lu",  1'b0, 5'd5,  5'd2,  1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, MEMW, 1'b0);
    memw("mw2", 1'b0);
    memw("mw3", 1'b0);
    step("mw_ready",   1'b0, 5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, NORM, 1'b0);
    idle("mw_done", NORM, 1'b0);
    step("zero_wait",  1'b0, 5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, NORM, 1'b0);
    step("lu_in_run",  1'b0, 5'd6,  5'd2,  1'b0, 1'b1, 5'd6,  1'b0, 1'b0, 1'b0, LU,   1'b0);

    memw("to1", 1'b0);
    memw("to2", 1'b0);
    memw("to3", 1'b0);
    memw("to4", 1'b0);
    memw("to5", 1'b0);
    memw("halt_memw", 1'b1);
    step("halt_ready", 1'b0, 5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, MEMW, 1'b1);
    step("halt_br",    1'b0, 5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, MEMW, 1'b1);
    for (int i = 0; i < 6; i++) idle("halt_sat", MEMW, 1'b1);
    reset_cycle("rst_halt", 1'b1);
    idle("post_halt", NORM, 1'b0);

    memw("abort1", 1'b0);
    memw("abort2", 1'b0);
    reset_cycle("rst_abort", 1'b0);
    memw("re1", 1'b0);
    memw("re2", 1'b0);
    memw("re3", 1'b0);
    memw("re4", 1'b0);
    step("re_ready",   1'b0, 5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, NORM, 1'b0);
    idle("final", NORM, 1'b0);

    for (int i = 0; i < 10 && name_q.size() != 0; i++) @(posedge clk);
    if (name_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", name_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
